wb_dest_tracker: RTL and testbench
==================================

// Module: wb_dest_tracker
// PURPOSE
//  Producer side of the ID-stage forwarding interface. Decodes the destination register
//  and write enable of the ID instruction and carries them down EXE->MEM->WB.
//  Drives the {EXE,MEM,WB}_wraddr/_wr_en pairs consumed by the forwarding unit.
//  Raises a load-use stall when an EXE-stage LW feeds the instruction in ID.
//  Handles external pipeline freeze, branch/jump flush and bubble insertion.
// PARAMETERS
//  REG_AW    5   register address width
//  LINK_REG  31  JAL destination register
// PORTS
//  clk            in   1   rising-edge clock; single clock domain
//  nrst           in   1   synchronous active-low reset
//  ID_inst        in   32  instruction currently in ID
//  ID_valid       in   1   ID_inst is a real instruction (0 = bubble)
//  flush          in   1   squash the ID instruction (taken branch/jump)
//  stall_ext      in   1   freeze the whole tracker (memory wait)
//  EXE_wraddr     out  5   EXE destination register
//  EXE_wr_en      out  1   EXE writes the register file
//  MEM_wraddr     out  5   MEM destination register
//  MEM_wr_en      out  1   MEM writes the register file
//  WB_wraddr      out  5   WB destination register
//  WB_wr_en       out  1   WB writes the register file
//  EXE_is_load    out  1   EXE holds an LW
//  loaduse_stall  out  1   hold PC/IF-ID this cycle (combinational)
// BEHAVIOUR
//  - Reset: on clk edge with nrst=0, all stage registers and all outputs = 0.
//    Reset mid-operation discards in-flight entries, and no write survives.
//  - Decode (opcode [31:26], func [5:0], rs [25:21], rt [20:16], rd [15:11]):
//    - op 0, func ADD 20/SUB 22/SLT 2a/SLL 00/SRL 02 -> dest rd.
//    - op 0, func JR 08 -> no write.
//    - ADDI 08, SLTI 0a, LW 23 -> dest rt.
//    - JAL 03 -> dest LINK_REG.
//    - SW 2b, BEQ 04, BNE 05, J 02, other opcodes -> no write.
//    - wr_en = has_dest & (dest != 0). Invariant: wraddr = 0 whenever wr_en = 0.
//  - Sources: readA = rs, except SLL/SRL/J/JAL -> 0.
//    readB = rt for op 0 (not JR) and SW/BEQ/BNE, otherwise 0.
//  - Advance each edge (nrst=1):
//    - stall_ext=1: hold all stages (highest priority).
//    - Otherwise: WB<=MEM, MEM<=EXE, EXE<=decode(ID_inst).
//    - EXE instead receives a bubble (wr_en=0, addr=0, is_load=0) when
//      ~ID_valid | flush | loaduse_stall.
//  - loaduse_stall = ID_valid & ~flush & EXE_is_load & EXE_wr_en &
//    (EXE_wraddr==readA | EXE_wraddr==readB); comparisons against reg 0 never match.
//    Exactly one stall cycle per hazard: the bubble clears EXE_is_load next edge.
//  - Simultaneous events:
//    - flush + hazard -> no stall; bubble inserted.
//    - stall_ext + hazard -> stall asserted, state held.
//  - Latency: ID decode visible on EXE_* 1 cycle later, MEM_* 2, WB_* 3 (no freezes).
// CONFIGURATION
//  - LOADUSE_STALL_EN defined: load-use detection as above.
//  - Undefined: loaduse_stall tied 0 and no hazard bubbles; software must schedule
//    a NOP after each LW. EXE_is_load still driven.
// STRUCTURE
//  - Package mips_pkg: opcode/func localparams (ADDI, SLTI, LW, SW, BEQ, BNE, J, JAL,
//    ADD, SUB, SLT, SLL, SRL, JR), REG_AW, and the stage-entry typedef
//    {wraddr, wr_en, is_load}. Shared with the forwarding unit.
//  - Sub-module dest_decoder: combinational ID_inst -> {dest, wr_en, is_load, readA, readB}.
//  - Top level: three stage registers plus hazard logic.
// TESTING
//  1. Reset: nrst=0 for 2 cycles mid-stream -> all outputs 0 the next cycle.
//  2. ADD $3,$1,$2 then NOPs -> EXE_wraddr=3/wr_en=1 at +1, MEM at +2, WB at +3, then 0.
//  3. LW $5,0($1) then ADD $6,$5,$0 -> loaduse_stall=1 for exactly 1 cycle; EXE bubble;
//     the ADD's dest 6 appears 1 cycle later. With macro undefined: stall never asserts.
//  4. ADDI $0,$1,4 and SW $7,0($1) -> wr_en=0, wraddr=0 at every stage.
//     JAL -> wraddr=31, wr_en=1.
//  5. flush=1 on the ADD after an LW $5 hazard -> no stall; EXE bubble.
//     stall_ext=1 for 3 cycles -> EXE/MEM/WB held unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the pipeline stage-entry type used by the
// destination tracker and the forwarding unit.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] LINK_REG_DEFAULT = 5'd31;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  // One pipeline stage worth of write-back information
  typedef struct packed {
    logic [REG_AW-1:0] wraddr;
    logic              wr_en;
    logic              is_load;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '{wraddr: 5'd0, wr_en: 1'b0, is_load: 1'b0};

  // Source/destination match; register 0 is hard-wired and never creates a dependency
  function automatic logic src_hit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
    return (src != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/dest_decoder.sv
// Combinational decode of an instruction into its destination register, write
// enable, load flag and the two source register numbers it reads.
module dest_decoder
  import mips_pkg::*;
#(
  parameter logic [REG_AW-1:0] LINK_REG = LINK_REG_DEFAULT
) (
  input  logic [31:0]       inst,
  output logic [REG_AW-1:0] dest,
  output logic              wr_en,
  output logic              is_load,
  output logic [REG_AW-1:0] read_a,
  output logic [REG_AW-1:0] read_b
);

  logic [5:0]        opcode_s;
  logic [5:0]        func_s;
  logic [REG_AW-1:0] rs_s;
  logic [REG_AW-1:0] rt_s;
  logic [REG_AW-1:0] rd_s;
  logic              has_dest_s;
  logic [REG_AW-1:0] dest_raw_s;
  logic              unused_shamt_s;

  assign opcode_s       = inst[31:26];
  assign rs_s           = inst[25:21];
  assign rt_s           = inst[20:16];
  assign rd_s           = inst[15:11];
  assign func_s         = inst[5:0];
  assign unused_shamt_s = ^inst[10:6];

  // Classify the instruction: which register it writes and which it reads
  always_comb begin
    has_dest_s = 1'b0;
    dest_raw_s = 5'd0;
    is_load    = 1'b0;
    read_a     = rs_s;
    read_b     = 5'd0;
    case (opcode_s)
      OP_RTYPE: begin
        read_b = rt_s;
        case (func_s)
          FN_ADD, FN_SUB, FN_SLT: begin
            has_dest_s = 1'b1;
            dest_raw_s = rd_s;
          end
          FN_SLL, FN_SRL: begin
            // shifts take the shift amount from the instruction, not rs
            has_dest_s = 1'b1;
            dest_raw_s = rd_s;
            read_a     = 5'd0;
          end
          FN_JR: begin
            read_b = 5'd0;
          end
          default: begin
            has_dest_s = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        has_dest_s = 1'b1;
        dest_raw_s = rt_s;
      end
      OP_LW: begin
        has_dest_s = 1'b1;
        dest_raw_s = rt_s;
        is_load    = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        read_b = rt_s;
      end
      OP_J: begin
        read_a = 5'd0;
      end
      OP_JAL: begin
        has_dest_s = 1'b1;
        dest_raw_s = LINK_REG;
        read_a     = 5'd0;
      end
      default: begin
        has_dest_s = 1'b0;
      end
    endcase
  end

  // Writes to $0 are dropped, and the address is forced to 0 whenever nothing is written
  assign wr_en = has_dest_s & (dest_raw_s != 5'd0);
  assign dest  = wr_en ? dest_raw_s : 5'd0;

endmodule

// File: rtl/wb_dest_tracker.sv
// Tracks destination register / write enable of each instruction from ID through
// EXE, MEM and WB for the forwarding unit, and detects load-use hazards.
// Optional feature macro: LOADUSE_STALL_EN (enables load-use stall detection;
// when undefined, loaduse_stall is tied low and no hazard bubbles are inserted).
module wb_dest_tracker
  import mips_pkg::*;
#(
  parameter logic [REG_AW-1:0] LINK_REG = LINK_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [31:0]       ID_inst,
  input  logic              ID_valid,
  input  logic              flush,
  input  logic              stall_ext,
  output logic [REG_AW-1:0] EXE_wraddr,
  output logic              EXE_wr_en,
  output logic [REG_AW-1:0] MEM_wraddr,
  output logic              MEM_wr_en,
  output logic [REG_AW-1:0] WB_wraddr,
  output logic              WB_wr_en,
  output logic              EXE_is_load,
  output logic              loaduse_stall
);

  stage_entry_t      exe_r;
  stage_entry_t      mem_r;
  stage_entry_t      wb_r;
  stage_entry_t      exe_next_s;
  logic [REG_AW-1:0] dec_dest_s;
  logic              dec_wr_en_s;
  logic              dec_is_load_s;
  logic [REG_AW-1:0] read_a_s;
  logic [REG_AW-1:0] read_b_s;
  logic              hazard_s;
  logic              unused_tail_s;

  dest_decoder #(
    .LINK_REG (LINK_REG)
  ) u_dest_decoder (
    .inst    (ID_inst),
    .dest    (dec_dest_s),
    .wr_en   (dec_wr_en_s),
    .is_load (dec_is_load_s),
    .read_a  (read_a_s),
    .read_b  (read_b_s)
  );

`ifdef LOADUSE_STALL_EN
  // Load in EXE whose result is read by the live ID instruction forces one bubble
  always_comb begin
    hazard_s = 1'b0;
    if (ID_valid && !flush && exe_r.is_load && exe_r.wr_en) begin
      hazard_s = src_hit(exe_r.wraddr, read_a_s) | src_hit(exe_r.wraddr, read_b_s);
    end else begin
      hazard_s = 1'b0;
    end
  end
`else
  logic unused_src_s;
  assign unused_src_s = ^{read_a_s, read_b_s};
  assign hazard_s     = 1'b0;
`endif

  assign loaduse_stall = hazard_s;

  // Entry that EXE takes on the next advance: decoded ID or a bubble
  always_comb begin
    exe_next_s = BUBBLE;
    if (ID_valid && !flush && !hazard_s) begin
      exe_next_s.wraddr  = dec_dest_s;
      exe_next_s.wr_en   = dec_wr_en_s;
      exe_next_s.is_load = dec_is_load_s;
    end else begin
      exe_next_s = BUBBLE;
    end
  end

  // Stage registers: reset clears everything, external freeze holds everything
  always_ff @(posedge clk) begin
    if (!nrst) begin
      exe_r <= BUBBLE;
      mem_r <= BUBBLE;
      wb_r  <= BUBBLE;
    end else if (stall_ext) begin
      exe_r <= exe_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end else begin
      wb_r  <= mem_r;
      mem_r <= exe_r;
      exe_r <= exe_next_s;
    end
  end

  assign EXE_wraddr    = exe_r.wraddr;
  assign EXE_wr_en     = exe_r.wr_en;
  assign EXE_is_load   = exe_r.is_load;
  assign MEM_wraddr    = mem_r.wraddr;
  assign MEM_wr_en     = mem_r.wr_en;
  assign WB_wraddr     = wb_r.wraddr;
  assign WB_wr_en      = wb_r.wr_en;
  assign unused_tail_s = mem_r.is_load ^ wb_r.is_load;

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Self-checking bench for wb_dest_tracker: directed scenarios followed by
// randomized traffic, all compared against a behavioural pipeline model.
module tb_wb_dest_tracker;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] ID_inst;
  logic        ID_valid;
  logic        flush;
  logic        stall_ext;
  logic [4:0]  EXE_wraddr;
  logic        EXE_wr_en;
  logic [4:0]  MEM_wraddr;
  logic        MEM_wr_en;
  logic [4:0]  WB_wraddr;
  logic        WB_wr_en;
  logic        EXE_is_load;
  logic        loaduse_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    bit wr;
    bit ld;
  } ent_t;

  ent_t pipe [3];   // 0 = EXE, 1 = MEM, 2 = WB

  wb_dest_tracker dut (
    .clk           (clk),
    .nrst          (nrst),
    .ID_inst       (ID_inst),
    .ID_valid      (ID_valid),
    .flush         (flush),
    .stall_ext     (stall_ext),
    .EXE_wraddr    (EXE_wraddr),
    .EXE_wr_en     (EXE_wr_en),
    .MEM_wraddr    (MEM_wraddr),
    .MEM_wr_en     (MEM_wr_en),
    .WB_wraddr     (WB_wraddr),
    .WB_wr_en      (WB_wr_en),
    .EXE_is_load   (EXE_is_load),
    .loaduse_stall (loaduse_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(input int fn, input int rs, input int rt, input int rd);
    logic [31:0] x;
    x = 32'd0;
    x[25:21] = rs[4:0];
    x[20:16] = rt[4:0];
    x[15:11] = rd[4:0];
    x[5:0]   = fn[5:0];
    return x;
  endfunction

  function automatic logic [31:0] i_inst(input int op, input int rs, input int rt, input int imm);
    logic [31:0] x;
    x = 32'd0;
    x[31:26] = op[5:0];
    x[25:21] = rs[4:0];
    x[20:16] = rt[4:0];
    x[15:0]  = imm[15:0];
    return x;
  endfunction

  // Reference decode written directly from the instruction-set rules
  function automatic void m_decode(input logic [31:0] inst, output ent_t e, output int ra, output int rb);
    int op, fn, rs, rt, rd, dst;
    bit has;
    op = int'(inst[31:26]);
    fn = int'(inst[5:0]);
    rs = int'(inst[25:21]);
    rt = int'(inst[20:16]);
    rd = int'(inst[15:11]);
    has = 0;
    dst = 0;
    if (op == 0 && (fn == 32 || fn == 34 || fn == 42 || fn == 0 || fn == 2)) begin
      has = 1; dst = rd;
    end else if (op == 8 || op == 10 || op == 35) begin
      has = 1; dst = rt;
    end else if (op == 3) begin
      has = 1; dst = 31;
    end
    e.wr   = has && (dst != 0);
    e.addr = e.wr ? dst : 0;
    e.ld   = (op == 35);
    ra = ((op == 0 && (fn == 0 || fn == 2)) || op == 2 || op == 3) ? 0 : rs;
    rb = ((op == 0 && fn != 8) || op == 43 || op == 4 || op == 5) ? rt : 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".EXE_wraddr"},  EXE_wraddr,  pipe[0].addr);
    check({tag, ".EXE_wr_en"},   EXE_wr_en,   pipe[0].wr);
    check({tag, ".EXE_is_load"}, EXE_is_load, pipe[0].ld);
    check({tag, ".MEM_wraddr"},  MEM_wraddr,  pipe[1].addr);
    check({tag, ".MEM_wr_en"},   MEM_wr_en,   pipe[1].wr);
    check({tag, ".WB_wraddr"},   WB_wraddr,   pipe[2].addr);
    check({tag, ".WB_wr_en"},    WB_wr_en,    pipe[2].wr);
  endtask

  // One clock cycle: drive, check the combinational stall, clock, update model, check stages
  task automatic step(input logic [31:0] inst, input bit v, input bit f, input bit sx,
                      input bit rn, output bit stalled);
    ent_t d;
    int   ra, rb;
    bit   st;
    ID_inst   = inst;
    ID_valid  = v;
    flush     = f;
    stall_ext = sx;
    nrst      = rn;
    #2;
    m_decode(inst, d, ra, rb);
    st = 0;
`ifdef LOADUSE_STALL_EN
    st = v && !f && pipe[0].ld && pipe[0].wr &&
         ((ra != 0 && ra == pipe[0].addr) || (rb != 0 && rb == pipe[0].addr));
`endif
    check("loaduse_stall", loaduse_stall, st);
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
    end else if (!sx) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (v && !f && !st) ? d : '{0, 0, 0};
    end
    #1;
    check_outputs("stage");
    stalled = st;
  endtask

  // Issue an instruction, re-presenting it while the tracker asks for a hold
  task automatic issue(input logic [31:0] inst, output int nstall);
    bit st;
    nstall = 0;
    step(inst, 1, 0, 0, 1, st);
    if (st) begin
      nstall++;
      step(inst, 1, 0, 0, 1, st);
      check("stall_once", st, 0);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    bit st;
    int ns;
    logic [31:0] inst;
    int op_pick, fn_pick;
    int ops [12] = '{0, 0, 0, 8, 10, 35, 35, 43, 4, 5, 2, 3};
    int fns [6]  = '{32, 34, 42, 0, 2, 8};

    ID_inst = NOP; ID_valid = 1'b0; flush = 1'b0; stall_ext = 1'b0; nrst = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.loaduse_stall", loaduse_stall, 1'b0);
    #5;

    // ADD $3,$1,$2 flows EXE -> MEM -> WB
    step(r_inst(32, 1, 2, 3), 1, 0, 0, 1, st);
    check("add.exe", {EXE_wr_en, EXE_wraddr}, {1'b1, 5'd3});
    step(NOP, 1, 0, 0, 1, st);
    check("add.mem", {MEM_wr_en, MEM_wraddr}, {1'b1, 5'd3});
    step(NOP, 1, 0, 0, 1, st);
    check("add.wb", {WB_wr_en, WB_wraddr}, {1'b1, 5'd3});
    step(NOP, 1, 0, 0, 1, st);
    check("add.drain", {WB_wr_en, WB_wraddr}, {1'b0, 5'd0});

    // LW $5,0($1) then ADD $6,$5,$0
    step(i_inst(35, 1, 5, 0), 1, 0, 0, 1, st);
    check("lw.exe_is_load", EXE_is_load, 1'b1);
    issue(r_inst(32, 5, 0, 6), ns);
`ifdef LOADUSE_STALL_EN
    check("lu.stall_cycles", ns, 1);
`else
    check("lu.stall_cycles", ns, 0);
`endif
    check("lu.add_dest", {EXE_wr_en, EXE_wraddr}, {1'b1, 5'd6});

    // No-write forms and JAL
    issue(i_inst(8, 1, 0, 4), ns);
    check("addi0.exe", {EXE_wr_en, EXE_wraddr}, {1'b0, 5'd0});
    issue(i_inst(43, 1, 7, 0), ns);
    check("sw.exe", {EXE_wr_en, EXE_wraddr}, {1'b0, 5'd0});
    check("addi0.mem", {MEM_wr_en, MEM_wraddr}, {1'b0, 5'd0});
    issue(i_inst(3, 0, 0, 16), ns);
    check("jal.exe", {EXE_wr_en, EXE_wraddr}, {1'b1, 5'd31});

    // Flush on top of a load-use hazard
    step(i_inst(35, 1, 5, 0), 1, 0, 0, 1, st);
    step(r_inst(32, 5, 0, 6), 1, 1, 0, 1, st);
    check("flush.exe", {EXE_wr_en, EXE_wraddr}, {1'b0, 5'd0});

    // External freeze for 3 cycles
    issue(r_inst(32, 1, 1, 3), ns);
    issue(r_inst(34, 1, 1, 4), ns);
    for (int i = 0; i < 3; i++) begin
      step(r_inst(42, 2, 2, 9), 1, 0, 1, 1, st);
      check("freeze.exe", EXE_wraddr, 5'd4);
      check("freeze.mem", MEM_wraddr, 5'd3);
    end

    // Freeze on top of a hazard: stall visible, state held
    step(i_inst(35, 2, 7, 0), 1, 0, 0, 1, st);
    step(r_inst(32, 7, 1, 8), 1, 0, 1, 1, st);
    check("freeze_hz.exe", {EXE_is_load, EXE_wraddr}, {1'b1, 5'd7});

    // Reset mid-stream
    step(r_inst(32, 1, 2, 11), 0, 0, 0, 0, st);
    step(r_inst(32, 1, 2, 12), 1, 0, 0, 0, st);
    check("midreset.all", {EXE_wr_en, MEM_wr_en, WB_wr_en, EXE_wraddr, MEM_wraddr, WB_wraddr}, 18'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      op_pick = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) op_pick = int'($urandom_range(0, 63));
      fn_pick = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 15) == 0) fn_pick = int'($urandom_range(0, 63));
      inst = {op_pick[5:0], 26'd0};
      inst[25:21] = 5'($urandom_range(0, 7));
      inst[20:16] = 5'($urandom_range(0, 7));
      inst[15:11] = 5'($urandom_range(0, 7));
      inst[10:6]  = 5'($urandom_range(0, 31));
      if (op_pick == 0) inst[5:0] = fn_pick[5:0];
      else inst[15:0] = 16'($urandom);
      step(inst,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 49) != 0,
           st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
